// File: rtl/pcie_tlp_tx_engine.sv
// Store-and-forward TLP transmit engine: header and payload queues feeding a
// framed tx beat bus with ready/valid backpressure.
module pcie_tlp_tx_engine #(
    parameter int DATA_WIDTH       = 256,
    parameter int TLP_HEADER_WIDTH = 128,
    parameter int LEN_WIDTH        = 4,
    parameter int HDR_DEPTH        = 4,
    parameter int DATA_DEPTH       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hdr_valid,
    output logic                        hdr_ready,
    input  logic [TLP_HEADER_WIDTH-1:0] hdr_in,
    input  logic [LEN_WIDTH-1:0]        hdr_len,
    input  logic                        dat_valid,
    output logic                        dat_ready,
    input  logic [DATA_WIDTH-1:0]       dat_in,
    output logic                        tx_valid,
    output logic [TLP_HEADER_WIDTH-1:0] tx_header,
    output logic [DATA_WIDTH-1:0]       tx_data,
    output logic                        tx_sop,
    output logic                        tx_eop,
    input  logic                        tx_ready,
    output logic [15:0]                 pkt_sent,
    output logic                        err_oversize
);

    // state | meaning
    // IDLE  | bus idle, waiting for an eligible head header
    // SEND  | a TLP beat is presented on the tx bus
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam int HA = $clog2(HDR_DEPTH);
    localparam int DA = $clog2(DATA_DEPTH);
    localparam logic [HA:0] HDR_FULL = (HA+1)'(HDR_DEPTH);
    localparam logic [DA:0] DAT_FULL = (DA+1)'(DATA_DEPTH);

    logic [TLP_HEADER_WIDTH-1:0] hdr_mem [HDR_DEPTH];
    logic [LEN_WIDTH-1:0]        len_mem [HDR_DEPTH];
    logic [DATA_WIDTH-1:0]       dat_mem [DATA_DEPTH];

    logic [HA-1:0]        hdr_wp, hdr_rp;
    logic [HA:0]          hdr_cnt;
    logic [DA-1:0]        dat_wp, dat_rp;
    logic [DA:0]          dat_cnt;
    logic [0:0]           state;
    logic [LEN_WIDTH-1:0] beats_left;

    logic [LEN_WIDTH-1:0]        head_len;
    logic [TLP_HEADER_WIDTH-1:0] head_hdr;
    logic hdr_push, dat_push, hdr_pop, dat_pop;
    logic head_oversize, head_elig, accept, start, drop, cont, finish;

    assign hdr_ready = (hdr_cnt != HDR_FULL);
    assign dat_ready = (dat_cnt != DAT_FULL);
    assign hdr_push  = hdr_valid & hdr_ready;
    assign dat_push  = dat_valid & dat_ready;

    assign head_len      = len_mem[hdr_rp];
    assign head_hdr      = hdr_mem[hdr_rp];
    assign head_oversize = (hdr_cnt != '0) && (int'(head_len) > DATA_DEPTH);
    assign head_elig     = (hdr_cnt != '0) && !head_oversize
                           && (int'(dat_cnt) >= int'(head_len));

    assign accept = tx_valid & tx_ready;
    assign finish = (state == S_SEND) && accept && tx_eop;
    assign cont   = (state == S_SEND) && accept && !tx_eop;
    // A finishing beat may chain straight into the next TLP's sop beat.
    assign start  = ((state == S_IDLE) || finish) && head_elig;
    assign drop   = (state == S_IDLE) && head_oversize;

    assign hdr_pop = start | drop;
    assign dat_pop = (start && (head_len != '0)) || cont;

    always_ff @(posedge clk) begin
        if (hdr_push) begin
            hdr_mem[hdr_wp] <= hdr_in;
            len_mem[hdr_wp] <= hdr_len;
        end
        if (dat_push) begin
            dat_mem[dat_wp] <= dat_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_wp  <= '0;
            hdr_rp  <= '0;
            hdr_cnt <= '0;
            dat_wp  <= '0;
            dat_rp  <= '0;
            dat_cnt <= '0;
        end else begin
            if (hdr_push) hdr_wp <= hdr_wp + 1'b1;
            if (hdr_pop)  hdr_rp <= hdr_rp + 1'b1;
            if (hdr_push && !hdr_pop)      hdr_cnt <= hdr_cnt + 1'b1;
            else if (!hdr_push && hdr_pop) hdr_cnt <= hdr_cnt - 1'b1;
            if (dat_push) dat_wp <= dat_wp + 1'b1;
            if (dat_pop)  dat_rp <= dat_rp + 1'b1;
            if (dat_push && !dat_pop)      dat_cnt <= dat_cnt + 1'b1;
            else if (!dat_push && dat_pop) dat_cnt <= dat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tx_valid     <= 1'b0;
            tx_sop       <= 1'b0;
            tx_eop       <= 1'b0;
            tx_header    <= '0;
            tx_data      <= '0;
            beats_left   <= '0;
            pkt_sent     <= '0;
            err_oversize <= 1'b0;
        end else begin
            if (finish) pkt_sent <= pkt_sent + 1'b1;
            if (drop)   err_oversize <= 1'b1;

            if (start) begin
                state      <= S_SEND;
                tx_valid   <= 1'b1;
                tx_sop     <= 1'b1;
                tx_header  <= head_hdr;
                tx_data    <= (head_len == '0) ? '0 : dat_mem[dat_rp];
                tx_eop     <= (head_len <= LEN_WIDTH'(1));
                beats_left <= (head_len == '0) ? '0 : head_len - 1'b1;
            end else if (cont) begin
                tx_data    <= dat_mem[dat_rp];
                tx_sop     <= 1'b0;
                tx_eop     <= (beats_left == LEN_WIDTH'(1));
                beats_left <= beats_left - 1'b1;
            end else if (finish) begin
                state    <= S_IDLE;
                tx_valid <= 1'b0;
                tx_sop   <= 1'b0;
                tx_eop   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcie_tlp_tx_engine.sv
// Bench for pcie_tlp_tx_engine: queue-level TLP model checked on every cycle,
// plus directed timing and boundary checks with literal expectations.
module tb_pcie_tlp_tx_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         hdr_valid, hdr_ready;
    logic [127:0] hdr_in;
    logic [3:0]   hdr_len;
    logic         dat_valid, dat_ready;
    logic [255:0] dat_in;
    logic         tx_valid, tx_sop, tx_eop, tx_ready;
    logic [127:0] tx_header;
    logic [255:0] tx_data;
    logic [15:0]  pkt_sent;
    logic         err_oversize;

    pcie_tlp_tx_engine dut (
        .clk(clk), .rst(rst),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_in(hdr_in), .hdr_len(hdr_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
        .tx_valid(tx_valid), .tx_header(tx_header), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready),
        .pkt_sent(pkt_sent), .err_oversize(err_oversize)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] h;
        int           len;
    } hdr_t;

    hdr_t         mhdr [$];
    logic [255:0] mdat [$];
    int           cmp_cnt = 0;
    int           err_cnt = 0;
    logic         chk_en  = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] dv(input int i);
        logic [31:0] w;
        w = 32'hD00D_0000 ^ 32'(i);
        return {8{w}};
    endfunction

    // Model: TLPs leave in header-push order, oversize headers vanish, each
    // TLP consumes len payload beats in data-push order.
    hdr_t         cur;
    int           idx;
    logic         in_pkt, hold_pending;
    logic [15:0]  m_sent;
    logic [127:0] h_hdr;
    logic [255:0] h_data, exp_data;
    logic         h_sop, h_eop, exp_eop;

    always @(negedge clk) begin
        if (rst || !chk_en) begin
            in_pkt       = 1'b0;
            hold_pending = 1'b0;
            m_sent       = '0;
        end else begin
            chk("pkt_sent", pkt_sent, m_sent);
            if (hold_pending) begin
                chk("hold_valid", tx_valid, 1'b1);
                chk("hold_header", tx_header, h_hdr);
                chk("hold_data", tx_data, h_data);
                chk("hold_sop", tx_sop, h_sop);
                chk("hold_eop", tx_eop, h_eop);
            end
            if (in_pkt) chk("no_bubble", tx_valid, 1'b1);
            if (tx_valid && tx_ready) begin
                if (!in_pkt) begin
                    while (mhdr.size() > 0 && mhdr[0].len > 8) void'(mhdr.pop_front());
                    if (mhdr.size() == 0) begin
                        chk("unexpected_beat", tx_valid, 1'b0);
                    end else begin
                        cur    = mhdr.pop_front();
                        idx    = 0;
                        in_pkt = 1'b1;
                    end
                end
                if (in_pkt) begin
                    if (cur.len == 0) exp_data = '0;
                    else if (mdat.size() > 0) exp_data = mdat.pop_front();
                    else exp_data = 'x;
                    exp_eop = (cur.len == 0) || (idx == cur.len - 1);
                    chk("beat_sop", tx_sop, idx == 0);
                    chk("beat_eop", tx_eop, exp_eop);
                    chk("beat_header", tx_header, cur.h);
                    chk("beat_data", tx_data, exp_data);
                    idx++;
                    if (exp_eop) begin
                        in_pkt = 1'b0;
                        m_sent = m_sent + 16'd1;
                    end
                end
            end
            hold_pending = tx_valid && !tx_ready;
            h_hdr  = tx_header;
            h_data = tx_data;
            h_sop  = tx_sop;
            h_eop  = tx_eop;
        end
    end

    task automatic push_hdr(input logic [127:0] h, input int len);
        logic acc;
        hdr_t e;
        hdr_in    = h;
        hdr_len   = len[3:0];
        hdr_valid = 1'b1;
        acc       = hdr_ready;
        @(posedge clk);
        if (acc) begin
            e.h   = h;
            e.len = len;
            mhdr.push_back(e);
        end
        #1 hdr_valid = 1'b0;
    endtask

    task automatic push_dat(input logic [255:0] d);
        logic acc;
        dat_in    = d;
        dat_valid = 1'b1;
        acc       = dat_ready;
        @(posedge clk);
        if (acc) mdat.push_back(d);
        #1 dat_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!tx_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, tx_valid, 1'b1);
    endtask

    initial begin
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b1; hdr_valid = 1'b0; dat_valid = 1'b0; tx_ready = 1'b0;
        hdr_in = '0; hdr_len = '0; dat_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_sop_eop", {tx_sop, tx_eop}, 2'b00);
        chk("rst_header", tx_header, 128'h0);
        chk("rst_data", tx_data, 256'h0);
        chk("rst_pkt_sent", pkt_sent, 16'd0);
        chk("rst_err", err_oversize, 1'b0);
        chk("rst_ready", {hdr_ready, dat_ready}, 2'b11);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // header-only TLP and push-to-valid latency
        tx_ready = 1'b1;
        push_hdr(128'hA5, 0);
        chk("lat_not_yet", tx_valid, 1'b0);
        @(posedge clk); #1;
        chk("ho_valid", tx_valid, 1'b1);
        chk("ho_sop_eop", {tx_sop, tx_eop}, 2'b11);
        chk("ho_header", tx_header, 128'hA5);
        chk("ho_data", tx_data, 256'h0);
        @(posedge clk); #1;
        chk("ho_idle", tx_valid, 1'b0);
        chk("ho_pkt_sent", pkt_sent, 16'd1);

        // len 3 under toggling backpressure
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_dat(dv(i));
        push_hdr(128'h3333_0000_1111, 3);
        wait_valid("l3_wait");
        chk("l3_first_data", tx_data, dv(0));
        for (int i = 0; i < 5; i++) begin
            tx_ready = pat[i];
            @(posedge clk); #1;
        end
        chk("l3_done", tx_valid, 1'b0);
        chk("l3_pkt_sent", pkt_sent, 16'd2);

        // starved payload, then completion
        tx_ready = 1'b1;
        push_hdr(128'h4444, 4);
        push_dat(dv(10));
        push_dat(dv(11));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("starve_idle", tx_valid, 1'b0);
        end
        push_dat(dv(12));
        push_dat(dv(13));
        chk("starve_visible", tx_valid, 1'b0);
        @(posedge clk); #1;
        chk("starve_start", tx_valid, 1'b1);
        chk("starve_sop", tx_sop, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        chk("starve_pkt_sent", pkt_sent, 16'd3);

        // back-to-back TLPs without idle gap
        tx_ready = 1'b0;
        for (int i = 20; i < 23; i++) push_dat(dv(i));
        push_hdr(128'h5A, 2);
        push_hdr(128'h5B, 1);
        wait_valid("b2b_wait");
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("b2b_valid", tx_valid, 1'b1);
            @(posedge clk); #1;
        end
        chk("b2b_done", tx_valid, 1'b0);
        chk("b2b_pkt_sent", pkt_sent, 16'd5);

        // oversize header dropped, later TLP unaffected
        chk("ovs_err_before", err_oversize, 1'b0);
        push_hdr(128'h99, 9);
        @(posedge clk); #1;
        chk("ovs_err_set", err_oversize, 1'b1);
        chk("ovs_no_beat", tx_valid, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        chk("ovs_no_beat2", tx_valid, 1'b0);
        push_dat(dv(30));
        push_hdr(128'h66, 1);
        @(posedge clk); #1;
        chk("ovs_next_valid", tx_valid, 1'b1);
        chk("ovs_next_data", tx_data, dv(30));
        @(posedge clk); #1;
        chk("ovs_pkt_sent", pkt_sent, 16'd6);
        chk("ovs_err_sticky", err_oversize, 1'b1);

        // reset in the middle of a TLP
        tx_ready = 1'b0;
        for (int i = 40; i < 44; i++) push_dat(dv(i));
        push_hdr(128'h77, 4);
        wait_valid("rst_wait");
        tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_beat2", tx_sop, 1'b0);
        chk_en = 1'b0;
        mhdr.delete();
        mdat.delete();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", tx_valid, 1'b0);
        chk("rst_mid_ready", {hdr_ready, dat_ready}, 2'b11);
        chk("rst_mid_pkt_sent", pkt_sent, 16'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_flushed", tx_valid, 1'b0);
        end
        push_dat(dv(50));
        push_hdr(128'h88, 1);
        wait_valid("post_rst_wait");
        chk("post_rst_data", tx_data, dv(50));
        @(posedge clk); #1;
        chk("post_rst_pkt_sent", pkt_sent, 16'd1);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
